// File: rtl/frame_deserializer.sv
// rtl/frame_deserializer.sv - LANES-wide serial-to-parallel frame assembler with valid/ready output register
module frame_deserializer #(
  parameter int DATA_WIDTH = 8,
  parameter int LANES = 1,
  localparam int BEATS = DATA_WIDTH / LANES,
  localparam int LEN_W = $clog2(BEATS) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [LANES-1:0]      serial_in,
  input  logic                  enable,
  input  logic                  start,
  input  logic [LEN_W-1:0]      frame_len,
  input  logic                  msb_first,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  overrun,
  output logic                  abort
);

  typedef enum logic {IDLE, RECV} state_t;

  state_t                state, state_nx;
  logic [LEN_W-1:0]      cnt, cnt_nx, len_q, len_nx, len_in, len_use, base_cnt;
  logic                  msb_q, msb_nx, msb_use;
  logic [DATA_WIDTH-1:0] sreg, sreg_nx, base, word;
  logic                  old_done, new_open, take, done, abort_nx;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  valid_q, overrun_q, abort_q;

  // Zero or oversize lengths collapse to a full-width frame.
  always_comb begin
    len_in = frame_len;
    if (frame_len == '0 || frame_len > LEN_W'(BEATS))
      len_in = LEN_W'(BEATS);
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    len_nx   = len_q;
    msb_nx   = msb_q;
    sreg_nx  = sreg;

    // A beat that finishes the open frame belongs to it; a start in that
    // same cycle only opens the next frame (empty, no abort).
    old_done = (state == RECV) && enable && (cnt + LEN_W'(1) == len_q);
    new_open = start && !old_done;
    abort_nx = new_open && (state == RECV);

    len_use  = new_open ? len_in : len_q;
    msb_use  = new_open ? msb_first : msb_q;
    base     = new_open ? '0 : sreg;
    base_cnt = new_open ? '0 : cnt;
    take     = enable && (new_open || state == RECV);

    if (msb_use)
      word = (base << LANES) | DATA_WIDTH'(serial_in);
    else
      word = base | (DATA_WIDTH'(serial_in) << (int'(base_cnt) * LANES));

    done = take && (base_cnt + LEN_W'(1) == len_use);

    if (done) begin
      sreg_nx = '0;
      cnt_nx  = '0;
      if (start && old_done) begin
        state_nx = RECV;
        len_nx   = len_in;
        msb_nx   = msb_first;
      end else begin
        state_nx = IDLE;
      end
    end else if (take) begin
      state_nx = RECV;
      cnt_nx   = base_cnt + LEN_W'(1);
      sreg_nx  = word;
      len_nx   = len_use;
      msb_nx   = msb_use;
    end else if (new_open) begin
      state_nx = RECV;
      cnt_nx   = '0;
      sreg_nx  = '0;
      len_nx   = len_in;
      msb_nx   = msb_first;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      len_q     <= '0;
      msb_q     <= 1'b0;
      sreg      <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      abort_q   <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      len_q     <= len_nx;
      msb_q     <= msb_nx;
      sreg      <= sreg_nx;
      abort_q   <= abort_nx;
      overrun_q <= 1'b0;
      // A held, unaccepted word wins over a newly completed one.
      if (done) begin
        if (!valid_q || out_ready) begin
          data_q  <= word;
          valid_q <= 1'b1;
        end else begin
          overrun_q <= 1'b1;
        end
      end else if (valid_q && out_ready) begin
        valid_q <= 1'b0;
        data_q  <= '0;
      end
    end
  end

  assign out_data  = valid_q ? data_q : '0;
  assign out_valid = valid_q;
  assign busy      = (state == RECV);
  assign overrun   = overrun_q;
  assign abort     = abort_q;

endmodule
